if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 159 +++++++++++++++
 tb/tb_if_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: keeps one memory request in flight and buffers up to two responses for decode.
// Latency: the grant in cycle N, rvalid in N+1 and if_valid in N+2; requests can then continue back to back.
// Backpressure: when decode stalls, requests stop once two words are buffered. A redirect flushes the buffer and drops the in-flight response.
// The optional starvation counter (stall_cnt port) is built only when the IF_STALL_CNT_EN macro is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_sel,
    input  logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        if_valid,
    input  logic        id_ready
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // RUN: nothing outstanding; WAIT: one response due; DROP: due response is stale
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fpc;
    logic [31:0] req_pc;

    // two-entry response buffer, head at rd_ptr
    logic [31:0] fifo_pc  [2];
    logic [31:0] fifo_ins [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic        push;
    logic        pop;
    logic        fire;
    logic [1:0]  count_after;
    logic [31:0] npc_aligned;
    logic        unused_npc_lo;

    assign npc_aligned   = {npc[31:2], 2'b00};
    assign unused_npc_lo = &{1'b0, npc[1:0]};

    // a redirect flushes the buffer, so it also suppresses any pop or push this cycle
    assign pop         = (count != 2'd0) && id_ready && !pc_sel;
    assign push        = (state == S_WAIT) && imem_rvalid && !pc_sel;
    assign count_after = count + {1'b0, push} - {1'b0, pop};

    // a new request is issued from RUN, or back to back when the current response lands.
    // In both cases the buffer must still have room after this cycle's push/pop.
    always_comb begin
        imem_req = 1'b0;
        if (!rst && !pc_sel) begin
            case (state)
                S_RUN:   imem_req = (count < 2'd2);
                S_WAIT:  imem_req = imem_rvalid && (count_after < 2'd2);
                default: imem_req = 1'b0;
            endcase
        end
    end

    assign fire      = imem_req && imem_gnt;
    assign imem_addr = {fpc[31:2], 2'b00};

    // decode sees the buffer head, or a NOP at pc 0 when nothing is buffered
    assign if_valid = (count != 2'd0);
    assign ins      = if_valid ? fifo_ins[rd_ptr] : NOP;
    assign pc       = if_valid ? fifo_pc[rd_ptr]  : 32'h0000_0000;

    // fetch FSM, fetch PC and buffer occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_RUN;
            fpc    <= RESET_PC;
            req_pc <= 32'h0000_0000;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (pc_sel) begin
            fpc    <= npc_aligned;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            case (state)
                S_RUN:   state <= S_RUN;
                // a response arriving in the redirect cycle is simply not pushed
                S_WAIT:  state <= imem_rvalid ? S_RUN : S_DROP;
                default: state <= imem_rvalid ? S_RUN : S_DROP;
            endcase
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_after;
            case (state)
                S_RUN: begin
                    // a stray rvalid here belongs to a request from before reset
                    if (fire) begin
                        req_pc <= fpc;
                        fpc    <= fpc + 32'd4;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (fire) begin
                            req_pc <= fpc;
                            fpc    <= fpc + 32'd4;
                            state  <= S_WAIT;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                default: begin
                    if (imem_rvalid) begin
                        state <= S_RUN;
                    end
                end
            endcase
        end
    end

    // buffer storage needs no reset; occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc[wr_ptr]  <= req_pc;
            fifo_ins[wr_ptr] <= imem_rdata;
        end
    end

`ifdef IF_STALL_CNT_EN
    // count cycles decode is ready but has nothing to take, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'h0000_0000;
        end else if (id_ready && !if_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage, using a behavioural instruction memory with programmable response latency.
// Every decode handshake is checked against an expected pc stream. The stream resets on reset and jumps on a redirect.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, pc_sel, imem_gnt, imem_rvalid, id_ready;
    logic [31:0] npc, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, ins, pc;
`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_sel      (pc_sel),
        .npc         (npc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ins         (ins),
        .pc          (pc),
        .if_valid    (if_valid),
        .id_ready    (id_ready)
`ifdef IF_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          lat    = 1;
    bit          pend   = 1'b0;
    int          pend_wait = 0;
    logic [31:0] paddr  = 32'h0;
    bit          last_g = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    int          pops   = 0;
    bit          track_lat = 1'b0;
    int          first_grant_cyc = -1;
    int          first_valid_cyc = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // first half of a cycle: memory drives its response, then outputs settle
    task automatic pre();
        if (pend && pend_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            if (pend) pend_wait--;
        end
        #1;
    endtask

    // second half: score the handshake, record a grant, advance to the next negedge
    task automatic post();
        if (!rst && if_valid && id_ready && !pc_sel) begin
            check("pop_pc", pc, exp_pc);
            check("pop_ins", ins, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
            if (track_lat && first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (pc_sel) exp_pc = {npc[31:2], 2'b00};
        if (rst)    exp_pc = 32'h0;
        last_g = imem_req && imem_gnt;
        if (last_g) begin
            pend      = 1'b1;
            pend_wait = lat - 1;
            paddr     = imem_addr;
            if (track_lat && first_grant_cyc < 0) first_grant_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            pre();
            post();
        end
    endtask

    task automatic run_until_grant(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            pre();
            post();
            got = last_g;
        end
        if (!got) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; pc_sel = 1'b0; npc = 32'h0; imem_gnt = 1'b0;
        id_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        cycles(2);

        // reset state while rst is still held
        pre();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_ins", ins, 32'h0000_0013);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
`ifdef IF_STALL_CNT_EN
        check("rst_stall", stall_cnt, 32'd0);
`endif
        post();

        // starvation: memory refuses grants for 10 cycles, decode ready
        rst = 1'b0; id_ready = 1'b1;
        cycles(10);

        // streaming from reset, 1-cycle memory
        imem_gnt = 1'b1; track_lat = 1'b1; pops = 0;
        pre();
`ifdef IF_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 32'd10);
`endif
        check("start_req", {31'd0, imem_req}, 32'd1);
        check("start_addr", imem_addr, 32'h0);
        post();
        cycles(11);
        check("stream_pops", pops, 32'd10);
        check("latency", first_valid_cyc - first_grant_cyc, 32'd2);
        track_lat = 1'b0;

        // decode backpressure: buffer fills and requests stop
        id_ready = 1'b0;
        cycles(5);
        pre();
        check("bp_req", {31'd0, imem_req}, 32'd0);
        check("bp_valid", {31'd0, if_valid}, 32'd1);
        post();
        id_ready = 1'b1; pops = 0;
        cycles(10);
        check("release_pops", pops, 32'd9);

        // redirect while a slow response is still pending
        lat = 3;
        run_until_grant("to_wait_grant");
        pc_sel = 1'b1; npc = 32'h0000_0102;
        pre();
        check("redir_rvalid", {31'd0, imem_rvalid}, 32'd0);
        check("redir_req", {31'd0, imem_req}, 32'd0);
        post();
        pc_sel = 1'b0; pops = 0;
        cycles(12);
        check("redir_pops", pops, 32'd2);

        // redirect in the same cycle as the response
        lat = 1;
        run_until_grant("same_cyc_grant");
        pc_sel = 1'b1; npc = 32'h0000_0203;
        pre();
        check("same_rvalid", {31'd0, imem_rvalid}, 32'd1);
        post();
        pc_sel = 1'b0;
        pre();
        check("same_addr", imem_addr, 32'h0000_0200);
        check("same_req", {31'd0, imem_req}, 32'd1);
        check("same_flush", {31'd0, if_valid}, 32'd0);
        post();
        cycles(6);

        // fetch address wraps at the top of the address space
        pc_sel = 1'b1; npc = 32'hFFFF_FFFE;
        pre();
        post();
        pc_sel = 1'b0;
        pre();
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        post();
        pre();
        check("wrap_addr", imem_addr, 32'h0000_0000);
        post();
        cycles(6);

        // reset with a request in flight: its late response must be ignored
        lat = 2;
        run_until_grant("pre_rst_grant");
        rst = 1'b1;
        pre();
        post();
        rst = 1'b0;
        pre();
        check("mid_rst_rvalid", {31'd0, imem_rvalid}, 32'd1);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        post();
        pops = 0;
        cycles(10);
        check("mid_rst_pops", pops, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
